// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back controller for the single register-file write port.
//   Round-robin arbitration among NREQ write-back sources with a
//   valid/ready handshake. The winning request is registered into one
//   write per cycle (rf_we/rf_waddr/rf_wdata). A per-register busy
//   scoreboard lets issue logic stall on outstanding destinations.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_addr/req_data     packed per-requester destination and data
//   rsv_valid/rsv_addr    destination reservation from issue
//   chk_addr1/2           source queries; chk_busy1/2 are combinational answers
//   busy                  full scoreboard vector
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   err_unrsv             sticky: a write committed to an unreserved register
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [AW-1:0]        chk_addr1,
  input  logic [AW-1:0]        chk_addr2,
  output logic                 chk_busy1,
  output logic                 chk_busy2,
  output logic [(2**AW)-1:0]   busy,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 err_unrsv
);

  localparam int PW   = $clog2(NREQ);
  localparam int NREG = 2**AW;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
    assign data_arr[gi] = req_data[gi*XLEN +: XLEN];
  end

  logic [PW-1:0]   ptr_reg;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   grant_idx;
  logic            found;

  // Round-robin search starting just after ptr: first the indices above
  // ptr, then wrap around to 0..ptr. Two plain passes avoid modulo math.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i > int'(ptr_reg))) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PW'(i);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i <= int'(ptr_reg))) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = PW'(i);
        end
      end
    end
  end

  assign req_ready = grant;

  logic            rf_we_reg;
  logic [AW-1:0]   rf_waddr_reg;
  logic [XLEN-1:0] rf_wdata_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic            err_reg;
  logic            err_next;

  // Set beats clear on the same address: a fresh reservation made while
  // the previous write lands is still outstanding. x0 is never busy.
  always_comb begin
    busy_next = busy_reg;
    if (rf_we_reg) begin
      busy_next[rf_waddr_reg] = 1'b0;
    end
    if (rsv_valid) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  assign err_next = err_reg |
                    (rf_we_reg && (rf_waddr_reg != '0) && !busy_reg[rf_waddr_reg]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg      <= PW'(NREQ - 1);
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      busy_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      err_reg  <= err_next;
      if (found) begin
        // A grant always coincides with valid, so found means transfer.
        ptr_reg      <= grant_idx;
        rf_waddr_reg <= addr_arr[grant_idx];
        rf_wdata_reg <= data_arr[grant_idx];
        rf_we_reg    <= (addr_arr[grant_idx] != '0);
      end else begin
        rf_we_reg <= 1'b0;
      end
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign busy      = busy_reg;
  assign err_unrsv = err_reg;
  assign chk_busy1 = busy_reg[chk_addr1];
  assign chk_busy2 = busy_reg[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed stimulus with literal checks,
// plus a per-cycle comparison against a behavioural model of the
// write-back port and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rsv_valid;
  logic [AW-1:0]        rsv_addr;
  logic [AW-1:0]        chk_addr1;
  logic [AW-1:0]        chk_addr2;
  logic                 chk_busy1;
  logic                 chk_busy2;
  logic [31:0]          busy;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 err_unrsv;

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_unrsv(err_unrsv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State after the most recent edge: the write port contents, the set of
  // reserved registers, the sticky error and the last granted requester.
  bit          m_known = 0;
  int          m_last;
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_busy [32];
  bit          m_err;

  // Winner = the valid requester at the smallest forward distance from last.
  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] r = '0;
    for (int a = 0; a < 32; a++) r[a] = m_busy[a];
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("ready_in_reset", 64'(req_ready), 64'd0);
      end else if (m_known) begin
        int w;
        logic [NREQ-1:0] eg;
        w  = pick(m_last, req_valid);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("m_ready", 64'(req_ready), 64'(eg));
      end
      if (m_known) begin
        check("m_rf_we", 64'(rf_we), 64'(m_we));
        check("m_rf_waddr", 64'(rf_waddr), 64'(m_waddr));
        check("m_rf_wdata", 64'(rf_wdata), 64'(m_wdata));
        check("m_busy", 64'(busy), 64'(busy_vec()));
        check("m_err", 64'(err_unrsv), 64'(m_err));
        check("m_chk_busy1", 64'(chk_busy1), 64'(m_busy[chk_addr1]));
        check("m_chk_busy2", 64'(chk_busy2), 64'(m_busy[chk_addr2]));
      end
      // Advance the model across the coming edge; inputs are stable here.
      if (rst) begin
        m_known = 1;
        m_last  = NREQ - 1;
        m_we    = 0;
        m_waddr = 0;
        m_wdata = '0;
        m_err   = 0;
        foreach (m_busy[a]) m_busy[a] = 0;
      end else if (m_known) begin
        int w;
        int a;
        if (m_we && m_waddr != 0 && !m_busy[m_waddr]) m_err = 1;
        if (m_we) m_busy[m_waddr] = 0;
        if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
        w = pick(m_last, req_valid);
        if (w >= 0) begin
          a       = int'(req_addr[w*AW +: AW]);
          m_last  = w;
          m_waddr = a;
          m_wdata = req_data[w*XLEN +: XLEN];
          m_we    = (a != 0);
        end else begin
          m_we = 0;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_addr[i*AW +: AW]     = a;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    chk_addr1 = '0;
    chk_addr2 = '0;

    // 1. reset with all requesters valid
    tick();
    check("t1_ready_rst_a", 64'(req_ready), 64'd0);
    tick();
    check("t1_ready_rst_b", 64'(req_ready), 64'd0);
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("t1_we", 64'(rf_we), 64'd0);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_err", 64'(err_unrsv), 64'd0);
    req_valid = 3'b111;
    #1;
    check("t1_first_grant", 64'(req_ready), 64'b001);
    tick();

    // 2. single reserved write to x5
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 5;
    tick();
    rsv_valid = 1'b0;
    set_req(0, 5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    check("t2_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    chk_addr1 = 5;
    #1;
    check("t2_we", 64'(rf_we), 64'd1);
    check("t2_waddr", 64'(rf_waddr), 64'd5);
    check("t2_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    check("t2_busy_during_we", 64'(chk_busy1), 64'd1);
    tick();
    check("t2_busy_after", 64'(chk_busy1), 64'd0);

    // 3. round-robin with all three requesters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      rsv_valid = 1'b1; rsv_addr = AW'(r);
      tick();
    end
    rsv_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'h100 + 32'(i));
    req_valid = 3'b111;
    #1;
    check("t3_g1", 64'(req_ready), 64'b001);
    tick();
    rsv_valid = 1'b1; rsv_addr = 1;  // re-reserve x1 while its write lands
    #1;
    check("t3_g2", 64'(req_ready), 64'b010);
    check("t3_wa1", 64'(rf_waddr), 64'd1);
    tick();
    rsv_valid = 1'b0;
    #1;
    check("t3_g3", 64'(req_ready), 64'b100);
    check("t3_wa2", 64'(rf_waddr), 64'd2);
    tick();
    check("t3_g4", 64'(req_ready), 64'b001);
    check("t3_wa3", 64'(rf_waddr), 64'd3);
    check("t3_we3", 64'(rf_we), 64'd1);
    tick();
    req_valid = '0;
    chk_addr1 = 1;
    #1;
    check("t3_wa4", 64'(rf_waddr), 64'd1);
    check("t3_busy1_held", 64'(chk_busy1), 64'd1);
    tick();
    check("t3_busy_clear", 64'(busy), 64'd0);
    check("t3_err", 64'(err_unrsv), 64'd0);

    // 4. requester 1 idle: 0 and 2 alternate
    set_req(0, 0, 32'hA0);
    set_req(2, 0, 32'hA2);
    req_valid = 3'b101;
    #1;
    check("t4_g1", 64'(req_ready), 64'b100);
    tick();
    check("t4_g2", 64'(req_ready), 64'b001);
    tick();
    check("t4_g3", 64'(req_ready), 64'b100);
    tick();
    check("t4_g4", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;

    // 5. x0 handling and set/clear collision on x7
    rsv_valid = 1'b1; rsv_addr = 0;
    tick();
    rsv_valid = 1'b0;
    check("t5_busy0", 64'(busy), 64'd0);
    set_req(1, 0, 32'h55);
    req_valid = 3'b010;
    #1;
    check("t5_x0_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    #1;
    check("t5_x0_we", 64'(rf_we), 64'd0);
    check("t5_x0_err", 64'(err_unrsv), 64'd0);
    rsv_valid = 1'b1; rsv_addr = 7;
    tick();
    rsv_valid = 1'b0;
    set_req(0, 7, 32'h77);
    req_valid = 3'b001;
    #1;
    check("t5_x7_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    rsv_valid = 1'b1; rsv_addr = 7;
    #1;
    check("t5_x7_we", 64'(rf_we), 64'd1);
    check("t5_x7_waddr", 64'(rf_waddr), 64'd7);
    tick();
    rsv_valid = 1'b0;
    chk_addr2 = 7;
    #1;
    check("t5_x7_busy", 64'(chk_busy2), 64'd1);
    check("t5_x7_err", 64'(err_unrsv), 64'd0);

    // 6. unreserved write to x9 sets the sticky error
    set_req(1, 9, 32'h99);
    req_valid = 3'b010;
    #1;
    check("t6_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    #1;
    check("t6_we", 64'(rf_we), 64'd1);
    check("t6_waddr", 64'(rf_waddr), 64'd9);
    check("t6_err_pre", 64'(err_unrsv), 64'd0);
    tick();
    check("t6_err_set", 64'(err_unrsv), 64'd1);
    tick();
    tick();
    check("t6_err_sticky", 64'(err_unrsv), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_err_rst", 64'(err_unrsv), 64'd0);
    check("t6_busy_rst", 64'(busy), 64'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
